alu_seq: RTL
============

# alu_seq

Parametrised sequential ALU with a registered result and a registered Z/N/C flag set, intended to replace the single-cycle combinational ALU in the SAP CPU datapath. It adds multi-cycle operations: barrel-free iterative shifts and an iterative multiply. It also adds a start/busy/done handshake so the control unit can stall on long operations. Flag-update rules are fixed per operation; for example, all logic ops clear carry, as the ANA/ORA/XRA instruction tests require.

## Interface
- `DATA_WIDTH`, default 8: operand, result and multiplier width; must be ≥ 4.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)`: width of the shift-amount field taken from `b_in`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `start`  in  1  request; sampled on the rising edge only while `busy`=0.
- `op`  in  4  operation code, latched with `start`.
- `a_in`  in  DATA_WIDTH  operand A, latched with `start`.
- `b_in`  in  DATA_WIDTH  operand B, latched with `start`. The shift amount is `b_in[SHAMT_W-1:0]`.
- `result`  out  DATA_WIDTH  registered result.
- `flag_zero`, `flag_negative`, `flag_carry`  out  1 each  registered flags.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse when `result` and the flags have been updated.

## Operation
Opcodes (0x0-0xF): AND, OR, XOR, NOT A, ADD, ADC, SUB, SBC, INC A, DEC A, SHL, SHR, ROL, ROR, MUL, CMP.
- ROL and ROR rotate by 1 through carry. SHL and SHR are logical shifts by n = `b_in[SHAMT_W-1:0]`.

Result and width rules (all arithmetic is modulo 2^DATA_WIDTH):
- ADD/ADC compute A+B(+C). C = carry out.
- SUB/SBC compute A−B(−C). C = borrow, i.e. 1 when the unsigned A < B (+C).
- INC/DEC leave C unchanged.
- AND/OR/XOR/NOT force C=0.
- SHL/SHR: C = the last bit shifted out. With n=0, result = A and C is unchanged.
- ROL/ROR: C = the bit rotated out.
- MUL: result = low half of the 2·DATA_WIDTH-bit unsigned product. C = 1 if the high half is nonzero.
- CMP: flags are computed exactly as for SUB. `result` keeps its previous value.

Flags for every op:
- Z = (new value == 0). For CMP, the value tested is the SUB difference.
- N = MSB of that same value.

FSM states:
- IDLE: `start`=1 with a single-cycle op (all ops except SHL/SHR with n≥2, and MUL) updates `result`/flags and pulses `done`. The FSM stays in IDLE.
- IDLE → SHIFT: on `start` with SHL/SHR and n≥2. A count register is loaded with n. The first shift step happens on the start edge.
- IDLE → MUL: on `start` with op MUL. Shift-and-add, one multiplier bit per edge, starting on the start edge.
- SHIFT/MUL → IDLE: on the final iteration edge. That edge writes `result`/flags and pulses `done`.

Boundary conditions:
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- Operand and `op` changes after the start edge are ignored.
- Flags change only on a `done` edge. They are never touched mid-iteration.
- `reset` asserted at any time, including mid-iteration, aborts the operation.
- Reset values: `result`=0, all flags=0, `busy`=0, `done`=0, FSM=IDLE.
- The first rising edge after `reset` deasserts may accept `start`.

## Timing
- Latency L is counted in rising edges, with the start edge as edge 1.
  - L=1: single-cycle ops, SHL/SHR with n≤1, ROL/ROR, CMP.
  - L=n: SHL/SHR with n≥2.
  - L=DATA_WIDTH: MUL.
- `result`/flags are valid, and `done`=1, in the cycle following edge L.
- `busy`=1 in the cycles following edges 1..L−1, and 0 when `done`=1.
- Back-to-back: `start` may be high in the same cycle that `done`=1; it is accepted at the next edge. Throughput for single-cycle ops is therefore 1 per cycle.
- `done` is high for exactly one cycle per accepted `start`.

## Test plan
- ADD 0xFF,0x01 → result 0x00, Z=1, C=1, N=0, L=1. Then AND 0xE1,0xFE → 0xE0, Z=0, N=1, C=0 (carry cleared).
- SUB 0x05,0x07 → 0xFE, N=1, C=1. Then CMP 0x07,0x07 → Z=1, N=0, C=0, result stays 0xFE. Then ADC with C=0: 0x7F+0x00 → 0x80, N=1, C=0.
- SHL 0x81 by 3 → `busy` high for 2 cycles, `done` after edge 3, result 0x08, C=0. SHR 0x81 by 1 → 0x40, C=1, L=1. SHL by 0 → result 0x81, C unchanged.
- MUL 0x0F×0x11 → 0xFF, N=1, C=0, done after edge 8. MUL 0x10×0x10 → 0x00, Z=1, C=1.
- Start MUL, then pulse `start` with AND on edge 3 → ignored: exactly one `done`, MUL result correct.
- Start MUL, assert `reset` after edge 4 → all outputs 0 immediately, no `done`. After release, ADD 0x02,0x03 → 0x05 with L=1.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with registered result/flags and start/busy/done handshake
//
// Purpose: replaces the single-cycle combinational SAP datapath ALU. Most ops
// complete on the start edge. SHL/SHR by n>=2 shift one bit per edge. MUL is a
// shift-and-add multiply that consumes one multiplier bit per edge.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          request, sampled only while busy=0
//   op             opcode, latched with start
//   a_in, b_in     operands, latched with start (shift amount = b_in[SHAMT_W-1:0])
//   result         registered result
//   flag_zero      registered Z flag
//   flag_negative  registered N flag
//   flag_carry     registered C flag
//   busy           iterative operation in progress
//   done           one-cycle pulse when result/flags have been written

module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag_zero,
    output logic                  flag_negative,
    output logic                  flag_carry,
    output logic                  busy,
    output logic                  done
);

    localparam int W      = DATA_WIDTH;
    localparam int CLOG_W = $clog2(DATA_WIDTH);
    // The counter holds either n-1 (shift) or W-1 (multiply).
    localparam int CNT_W  = (SHAMT_W > CLOG_W) ? SHAMT_W : CLOG_W;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_NOT = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SBC = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_ROL = 4'hC;
    localparam logic [3:0] OP_ROR = 4'hD;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    result_q;
    logic            zero_q;
    logic            neg_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]    work_q;    // shift operand, or remaining multiplier bits
    logic            dir_q;     // 1 = shift right
    logic [2*W-1:0]  acc_q;     // partial product
    logic [2*W-1:0]  mcand_q;   // multiplicand, pre-shifted to the current bit weight

    logic [SHAMT_W-1:0] shamt;
    logic               shift_op;
    logic               multi_shift;
    logic [W:0]         ext_d;
    logic [W-1:0]       alu_res_d;
    logic               alu_c_d;
    logic [W-1:0]       shift_nxt_d;
    logic               shift_bit_d;
    logic [2*W-1:0]     acc_nxt_d;

    assign shamt       = b_in[SHAMT_W-1:0];
    assign shift_op    = (op == OP_SHL) || (op == OP_SHR);
    assign multi_shift = shift_op && (shamt >= SHAMT_W'(2));

    // Single-cycle datapath. For CMP alu_res_d is the difference used only
    // for the flags; the result register is left alone.
    always_comb begin
        ext_d     = '0;
        alu_res_d = result_q;
        alu_c_d   = carry_q;
        case (op)
            OP_AND: begin alu_res_d = a_in & b_in; alu_c_d = 1'b0; end
            OP_OR:  begin alu_res_d = a_in | b_in; alu_c_d = 1'b0; end
            OP_XOR: begin alu_res_d = a_in ^ b_in; alu_c_d = 1'b0; end
            OP_NOT: begin alu_res_d = ~a_in;       alu_c_d = 1'b0; end
            OP_ADD: begin
                ext_d     = {1'b0, a_in} + {1'b0, b_in};
                alu_res_d = ext_d[W-1:0];
                alu_c_d   = ext_d[W];
            end
            OP_ADC: begin
                ext_d     = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, carry_q};
                alu_res_d = ext_d[W-1:0];
                alu_c_d   = ext_d[W];
            end
            OP_SUB, OP_CMP: begin
                // Bit W of the extended difference is the borrow.
                ext_d     = {1'b0, a_in} - {1'b0, b_in};
                alu_res_d = ext_d[W-1:0];
                alu_c_d   = ext_d[W];
            end
            OP_SBC: begin
                ext_d     = {1'b0, a_in} - {1'b0, b_in} - {{W{1'b0}}, carry_q};
                alu_res_d = ext_d[W-1:0];
                alu_c_d   = ext_d[W];
            end
            OP_INC: alu_res_d = a_in + W'(1);
            OP_DEC: alu_res_d = a_in - W'(1);
            OP_SHL: begin
                // Only n=0 and n=1 take this path.
                if (shamt == '0) begin
                    alu_res_d = a_in;
                end else begin
                    alu_res_d = {a_in[W-2:0], 1'b0};
                    alu_c_d   = a_in[W-1];
                end
            end
            OP_SHR: begin
                if (shamt == '0) begin
                    alu_res_d = a_in;
                end else begin
                    alu_res_d = {1'b0, a_in[W-1:1]};
                    alu_c_d   = a_in[0];
                end
            end
            OP_ROL: begin alu_res_d = {a_in[W-2:0], carry_q}; alu_c_d = a_in[W-1]; end
            OP_ROR: begin alu_res_d = {carry_q, a_in[W-1:1]}; alu_c_d = a_in[0];   end
            default: ;
        endcase
    end

    // One step of the iterative shift and of the shift-and-add multiply.
    always_comb begin
        shift_nxt_d = dir_q ? {1'b0, work_q[W-1:1]} : {work_q[W-2:0], 1'b0};
        shift_bit_d = dir_q ? work_q[0] : work_q[W-1];
        acc_nxt_d   = acc_q + (work_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            dir_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            // Bit 0 of the multiplier is consumed on the start edge.
                            acc_q   <= b_in[0] ? {{W{1'b0}}, a_in} : '0;
                            mcand_q <= {{(W-1){1'b0}}, a_in, 1'b0};
                            work_q  <= {1'b0, b_in[W-1:1]};
                            cnt_q   <= CNT_W'(W - 1);
                            busy_q  <= 1'b1;
                            state_q <= S_MUL;
                        end else if (multi_shift) begin
                            // First shift step on the start edge; n-1 remain.
                            dir_q   <= (op == OP_SHR);
                            work_q  <= (op == OP_SHR) ? {1'b0, a_in[W-1:1]}
                                                      : {a_in[W-2:0], 1'b0};
                            cnt_q   <= CNT_W'(shamt) - CNT_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= S_SHIFT;
                        end else begin
                            if (op != OP_CMP) begin
                                result_q <= alu_res_d;
                            end
                            zero_q  <= (alu_res_d == '0);
                            neg_q   <= alu_res_d[W-1];
                            carry_q <= alu_c_d;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= shift_nxt_d;
                        zero_q   <= (shift_nxt_d == '0);
                        neg_q    <= shift_nxt_d[W-1];
                        carry_q  <= shift_bit_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        work_q <= shift_nxt_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= acc_nxt_d[W-1:0];
                        zero_q   <= (acc_nxt_d[W-1:0] == '0);
                        neg_q    <= acc_nxt_d[W-1];
                        carry_q  <= |acc_nxt_d[2*W-1:W];
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        acc_q   <= acc_nxt_d;
                        mcand_q <= {mcand_q[2*W-2:0], 1'b0};
                        work_q  <= {1'b0, work_q[W-1:1]};
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result        = result_q;
    assign flag_zero     = zero_q;
    assign flag_negative = neg_q;
    assign flag_carry    = carry_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
